// File: rtl/isqrt_rr_share.sv
// Round-robin shared pipelined integer square root with per-result requester tags.
// Optional per-requester grant counters are enabled by defining ISQRT_RR_SHARE_STATS_EN.

module isqrt_pipe #(
  parameter int N_STAGES = 4
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [15:0] y
);

  typedef struct packed {
    logic [31:0] xs;
    logic [19:0] rem;
    logic [15:0] root;
  } sq_t;

  // One restoring digit step: consume the top two radicand bits, try root*4+1.
  function automatic sq_t sq_step(input sq_t a);
    sq_t        r;
    logic [19:0] rem_sh;
    logic [19:0] trial;
    rem_sh = {a.rem[17:0], a.xs[31:30]};
    trial  = {2'b00, a.root, 2'b01};
    r.xs   = {a.xs[29:0], 2'b00};
    if (rem_sh >= trial) begin
      r.rem  = rem_sh - trial;
      r.root = {a.root[14:0], 1'b1};
    end else begin
      r.rem  = rem_sh;
      r.root = {a.root[14:0], 1'b0};
    end
    return r;
  endfunction

  // The 16 digit steps are spread as evenly as possible over the stages.
  function automatic sq_t stage_run(input sq_t a, input int s);
    sq_t c;
    c = a;
    for (int k = 0; k < 16; k++) begin
      if (k >= (s * 16) / N_STAGES && k < ((s + 1) * 16) / N_STAGES) begin
        c = sq_step(c);
      end
    end
    return c;
  endfunction

  sq_t                 st_q [N_STAGES];
  sq_t                 st_d [N_STAGES];
  sq_t                 cur;
  logic [N_STAGES-1:0] vld_q;
  logic [N_STAGES-1:0] en;

  always_comb begin
    en     = '0;
    en[0]  = x_vld;
    for (int s = 1; s < N_STAGES; s++) begin
      en[s] = vld_q[s-1];
    end
    cur    = '0;
    cur.xs = x;
    st_d[0] = stage_run(cur, 0);
    for (int s = 1; s < N_STAGES; s++) begin
      st_d[s] = stage_run(st_q[s-1], s);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      vld_q <= '0;
    end else begin
      vld_q <= en;
    end
  end

  // Data registers only load behind a valid so idle stages do not toggle.
  always_ff @(posedge clk) begin
    for (int s = 0; s < N_STAGES; s++) begin
      if (en[s]) begin
        st_q[s] <= st_d[s];
      end
    end
  end

  assign y_vld = vld_q[N_STAGES-1];
  assign y     = st_q[N_STAGES-1].root;

endmodule

module isqrt_rr_share #(
  parameter int N_REQ         = 4,
  parameter int N_PIPE_STAGES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_vld,
  input  logic [32*N_REQ-1:0]  req_x,
  output logic [N_REQ-1:0]     req_rdy,
  output logic [N_REQ-1:0]     res_vld,
  output logic [31:0]          res_y,
  output logic                 busy
`ifdef ISQRT_RR_SHARE_STATS_EN
  ,
  output logic [16*N_REQ-1:0]  grant_cnt
`endif
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  idx;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_any;
  logic [N_REQ-1:0] gnt;
  logic [31:0]      gnt_x;

  logic             vld_p0;
  logic [ID_W-1:0]  id_p0;
  logic [31:0]      x_p0;

  logic [N_PIPE_STAGES-1:0] tag_vld;
  logic [ID_W-1:0]          tag_id [N_PIPE_STAGES];

  logic        isqrt_rst;
  logic        y_vld;
  logic [15:0] y;

  // Round-robin search from pointer+1; nothing is granted while reset is held.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    gnt_x   = '0;
    idx     = ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + ID_W'(1);
      if (!gnt_any && req_vld[idx] && rst) begin
        gnt_any     = 1'b1;
        gnt_id      = idx;
        gnt[idx]    = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_x = req_x[32*i +: 32];
      end
    end
  end

  assign req_rdy = gnt;

  // Stage p0: granted argument and its tag are registered at the handshake edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q  <= ID_W'(N_REQ - 1);
      vld_p0 <= 1'b0;
      id_p0  <= '0;
    end else begin
      vld_p0 <= gnt_any;
      id_p0  <= gnt_id;
      if (gnt_any) begin
        ptr_q <= gnt_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    x_p0 <= gnt_x;
  end

  assign isqrt_rst = !rst;

  isqrt_pipe #(
    .N_STAGES (N_PIPE_STAGES)
  ) u_isqrt (
    .clk   (clk),
    .arst  (isqrt_rst),
    .x_vld (vld_p0),
    .x     (x_p0),
    .y_vld (y_vld),
    .y     (y)
  );

  // Tag pipe: runs in lock-step with the isqrt stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld <= '0;
      for (int s = 0; s < N_PIPE_STAGES; s++) begin
        tag_id[s] <= '0;
      end
    end else begin
      tag_vld[0] <= vld_p0;
      tag_id[0]  <= id_p0;
      for (int s = 1; s < N_PIPE_STAGES; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

  tag_align_a: assert property (@(posedge clk) disable iff (!rst)
    tag_vld[N_PIPE_STAGES-1] == y_vld);

  // Output register stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_vld <= '0;
      res_y   <= '0;
    end else if (y_vld) begin
      res_vld <= N_REQ'(1) << tag_id[N_PIPE_STAGES-1];
      res_y   <= {16'h0000, y};
    end else begin
      res_vld <= '0;
    end
  end

  assign busy = vld_p0 | (|tag_vld) | (|res_vld);

`ifdef ISQRT_RR_SHARE_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] cnt_q [N_REQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i]) begin
          cnt_q[i] <= sat_inc(cnt_q[i]);
        end
      end
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
    assign grant_cnt[16*i +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_isqrt_rr_share.sv
// Randomised and directed bench for isqrt_rr_share against a queue-based reference model.
// Grant-counter checks are included when ISQRT_RR_SHARE_STATS_EN is defined.

module tb_isqrt_rr_share;

  localparam int NR = 4;
  localparam int NP = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_vld;
  logic [32*NR-1:0]  req_x;
  logic [NR-1:0]     req_rdy;
  logic [NR-1:0]     res_vld;
  logic [31:0]       res_y;
  logic              busy;
`ifdef ISQRT_RR_SHARE_STATS_EN
  logic [16*NR-1:0]  grant_cnt;
`endif

  isqrt_rr_share #(
    .N_REQ         (NR),
    .N_PIPE_STAGES (NP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_x     (req_x),
    .req_rdy   (req_rdy),
    .res_vld   (res_vld),
    .res_y     (res_y),
    .busy      (busy)
`ifdef ISQRT_RR_SHARE_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint ref_isqrt(input longint v);
    longint r;
    r = longint'($floor($sqrt(real'(v))));
    while (r * r > v) r--;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  typedef struct {
    int     due;
    int     id;
    longint y;
  } exp_t;

  exp_t          q[$];
  int            cyc = 0;
  int            mptr;
  int            mcnt [NR];
  logic [NR-1:0] ev;
  logic [NR-1:0] er;
  logic [31:0]   ey;
  int            g;
  int            idx;
  exp_t          e;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model and compare, evaluated mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      mptr = NR - 1;
      for (int i = 0; i < NR; i++) mcnt[i] = 0;
      chk("rst_res_vld", res_vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdy", req_rdy, 0);
`ifdef ISQRT_RR_SHARE_STATS_EN
      chk("rst_cnt", grant_cnt, 0);
`endif
    end else begin
      ev = '0;
      ey = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        ev = NR'(1) << q[0].id;
        ey = 32'(q[0].y);
        void'(q.pop_front());
      end
      chk("res_vld", res_vld, ev);
      if (ev != 0) chk("res_y", res_y, ey);
      chk("busy", busy, ((ev != 0) || (q.size() > 0)) ? 1 : 0);
`ifdef ISQRT_RR_SHARE_STATS_EN
      for (int i = 0; i < NR; i++) chk("grant_cnt", grant_cnt[16*i +: 16], mcnt[i]);
`endif
      g = -1;
      for (int k = 1; k <= NR; k++) begin
        idx = (mptr + k) % NR;
        if (g < 0 && req_vld[idx]) g = idx;
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("req_rdy", req_rdy, er);
      if (g >= 0) begin
        e.due = cyc + NP + 2;
        e.id  = g;
        e.y   = ref_isqrt(longint'(req_x[32*g +: 32]));
        q.push_back(e);
        mptr = g;
        if (mcnt[g] < 65535) mcnt[g]++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b0;
    req_vld = '0;
    req_x   = '0;

    chk("ref_144", ref_isqrt(144), 12);
    chk("ref_0", ref_isqrt(0), 0);
    chk("ref_3", ref_isqrt(3), 1);
    chk("ref_15", ref_isqrt(15), 3);
    chk("ref_max", ref_isqrt(64'd4294967295), 65535);

    repeat (3) step();
    req_vld = '1;
    #1 chk("rdy_in_rst", req_rdy, 0);
    req_vld = '0;
    step();
    rst = 1'b1;
    step();

    // single requester
    req_x[64 +: 32] = 144;
    req_vld = 4'b0100;
    #1 chk("single_rdy", req_rdy, 4'b0100);
    step();
    req_vld = '0;
    repeat (NP) step();
    chk("single_early", res_vld, 0);
    step();
    chk("single_vld", res_vld, 4'b0100);
    chk("single_y", res_y, 12);
    repeat (4) step();

    // full contention straight out of reset
    rst = 1'b0;
    for (int i = 0; i < NR; i++) req_x[32*i +: 32] = (i + 1) * (i + 1);
    req_vld = '1;
    step();
    rst = 1'b1;
    #1;
    for (int m = 0; m < 12; m++) begin
      chk("fc_rdy", req_rdy, 64'(1 << (m % NR)));
      if (m >= NP + 2) begin
        chk("fc_vld", res_vld, 64'(1 << ((m - NP - 2) % NR)));
        chk("fc_y", res_y, 64'(((m - NP - 2) % NR) + 1));
      end
      @(posedge clk);
      #2;
    end

    // pointer now at 3: wrap to 0, skip absent requesters
    req_vld = 4'b1010;
    #1 chk("wrap_rdy0", req_rdy, 4'b0010);
    @(posedge clk); #2 chk("wrap_rdy1", req_rdy, 4'b1000);
    @(posedge clk); #2 chk("wrap_rdy2", req_rdy, 4'b0010);
    req_vld = '0;
    repeat (NP + 4) step();

    // back-to-back stream from requester 1
    for (int v = 0; v < 48; v++) begin
      req_vld = 4'b0010;
      req_x[32 +: 32] = (v < 40) ? 32'(v) :
                        (v == 40) ? 32'hFFFF_FFFF :
                        (v == 41) ? 32'hFFFE_0001 :
                        (v == 42) ? 32'hFFFE_0000 : $urandom;
      #1 chk("b2b_rdy", req_rdy, 4'b0010);
      step();
    end
    req_vld = '0;
    repeat (NP + 4) step();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      req_vld = NR'($urandom);
      for (int i = 0; i < NR; i++) begin
        case ($urandom_range(0, 3))
          0:       req_x[32*i +: 32] = $urandom_range(0, 300);
          1:       req_x[32*i +: 32] = 32'hFFFF_FFFF - $urandom_range(0, 3);
          default: req_x[32*i +: 32] = $urandom;
        endcase
      end
      step();
    end
    req_vld = '0;
    repeat (NP + 4) step();

    // reset with three arguments in flight
    req_vld = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      req_x[31:0] = 100 + k;
      step();
    end
    req_vld = '0;
    chk("mf_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    chk("mf_vld", res_vld, 0);
    chk("mf_busy", busy, 0);
    step();
    rst = 1'b1;
    repeat (NP + 6) step();

`ifdef ISQRT_RR_SHARE_STATS_EN
    rst = 1'b0;
    step();
    rst = 1'b1;
    req_vld = 4'b0001;
    repeat (10) step();
    req_vld = 4'b0100;
    repeat (3) step();
    req_vld = '0;
    step();
    chk("cnt0", grant_cnt[15:0], 10);
    chk("cnt1", grant_cnt[31:16], 0);
    chk("cnt2", grant_cnt[47:32], 3);
    chk("cnt3", grant_cnt[63:48], 0);
    req_vld = 4'b0001;
    repeat (70000) step();
    req_vld = '0;
    step();
    chk("cnt_sat", grant_cnt[15:0], 16'hFFFF);
    repeat (NP + 4) step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
